// File: rtl/dti_tniu_sys_side_mux_pkg.sv
// -----------------------------------------------------------------------------
// dti_tniu_sys_side_mux_pkg
// Shared definitions for the system-side TNIU mux: default DTI field widths,
// the flit layout {payload, srcid, tgtid, qos, last} with last at bit 0,
// field bit offsets and the TX arbiter state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dti_tniu_sys_side_mux_pkg;

   localparam int DTI_DATA_W = 80;
   localparam int DTI_KEEP_W = 10;
   localparam int DTI_ID_W   = 6;
   localparam int DTI_FLIT_W = DTI_DATA_W + DTI_KEEP_W + 2 * DTI_ID_W + 2;

   // Fixed low-order field positions; the id-width dependent ones come from the helpers
   localparam int FLIT_LAST_BIT = 0;
   localparam int FLIT_QOS_BIT  = 1;
   localparam int FLIT_TGT_LSB  = 2;

   typedef struct packed {
      logic [DTI_DATA_W+DTI_KEEP_W-1:0] payload;
      logic [DTI_ID_W-1:0]              srcid;
      logic [DTI_ID_W-1:0]              tgtid;
      logic                             qos;
      logic                             last;
   } dti_flit_t;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } tniu_arb_st_e;

   function automatic int flit_src_lsb(input int id_w);
      return FLIT_TGT_LSB + id_w;
   endfunction

   function automatic int flit_payload_lsb(input int id_w);
      return FLIT_TGT_LSB + 2 * id_w;
   endfunction

endpackage

// File: rtl/dti_tniu_sys_side_mux_if.sv
// -----------------------------------------------------------------------------
// dti_tniu_sys_side_mux_if
// Bundles the CH_NUM DTI response/request streams and the TX/RX flit channels.
//   slave  : view of the mux itself (consumes up_rsp/fl_rx, produces fl_tx/dn_req)
//   master : view of the surrounding system / testbench
// -----------------------------------------------------------------------------
interface dti_tniu_sys_side_mux_if #(
   parameter int CH_NUM = 4,
   parameter int DATA_W = 80,
   parameter int KEEP_W = 10,
   parameter int ID_W   = 6
);
   localparam int FLIT_W = DATA_W + KEEP_W + 2 * ID_W + 2;

   logic [CH_NUM-1:0]        up_rsp_tvalid;
   logic [CH_NUM*DATA_W-1:0] up_rsp_tdata;
   logic [CH_NUM*KEEP_W-1:0] up_rsp_tkeep;
   logic [CH_NUM-1:0]        up_rsp_tlast;
   logic [CH_NUM*ID_W-1:0]   up_rsp_ttid;
   logic [CH_NUM-1:0]        up_rsp_tready;
   logic                     fl_tx_vld;
   logic [FLIT_W-1:0]        fl_tx_pld;
   logic                     fl_tx_rdy;
   logic                     fl_rx_vld;
   logic [FLIT_W-1:0]        fl_rx_pld;
   logic                     fl_rx_rdy;
   logic [CH_NUM-1:0]        dn_req_tvalid;
   logic [CH_NUM*DATA_W-1:0] dn_req_tdata;
   logic [CH_NUM*KEEP_W-1:0] dn_req_tkeep;
   logic [CH_NUM-1:0]        dn_req_tlast;
   logic [CH_NUM*ID_W-1:0]   dn_req_ttid;
   logic [CH_NUM-1:0]        dn_req_tready;

   modport slave (
      input  up_rsp_tvalid, up_rsp_tdata, up_rsp_tkeep, up_rsp_tlast, up_rsp_ttid,
      output up_rsp_tready,
      output fl_tx_vld, fl_tx_pld,
      input  fl_tx_rdy,
      input  fl_rx_vld, fl_rx_pld,
      output fl_rx_rdy,
      output dn_req_tvalid, dn_req_tdata, dn_req_tkeep, dn_req_tlast, dn_req_ttid,
      input  dn_req_tready
   );

   modport master (
      output up_rsp_tvalid, up_rsp_tdata, up_rsp_tkeep, up_rsp_tlast, up_rsp_ttid,
      input  up_rsp_tready,
      input  fl_tx_vld, fl_tx_pld,
      output fl_tx_rdy,
      output fl_rx_vld, fl_rx_pld,
      input  fl_rx_rdy,
      input  dn_req_tvalid, dn_req_tdata, dn_req_tkeep, dn_req_tlast, dn_req_ttid,
      output dn_req_tready
   );
endinterface

// File: rtl/dti_tniu_sys_side_mux_skid2.sv
// -----------------------------------------------------------------------------
// dti_tniu_skid2
// Two-entry valid/ready FIFO used once per RX channel.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i/push_data_i : write strobe and entry
//   pop_i         : head consumed this cycle
//   vld_o/data_o  : head valid and head entry
//   full_o        : both entries occupied (registered count only)
// -----------------------------------------------------------------------------
module dti_tniu_skid2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic [1:0]       cnt_d;
   logic             push_s;
   logic             pop_s;

   assign push_s = push_i && (cnt_q != 2'd2);
   assign pop_s  = pop_i && (cnt_q != 2'd0);

   // Occupancy next state; simultaneous push and pop leave it unchanged
   always_comb begin
      cnt_d = cnt_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage, pointers and count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   assign vld_o  = (cnt_q != 2'd0);
   assign data_o = mem_q[rd_ptr_q];
   assign full_o = (cnt_q == 2'd2);
endmodule

// File: rtl/dti_tniu_sys_side_mux.sv
// -----------------------------------------------------------------------------
// dti_tniu_sys_side_mux
// System-side TNIU stage. TX: packet-atomic round-robin merge of CH_NUM DTI
// response streams into one registered flit channel. RX: routes incoming
// flits by tgtid into per-channel 2-entry FIFOs feeding the DTI request streams.
//   clk, rst  : clock, asynchronous active-high reset
//   dti_if    : slave modport of dti_tniu_sys_side_mux_if (all stream/flit signals)
//   err_tgt_o : sticky flag, an out-of-range tgtid flit was dropped
// Optional: define DTI_TNIU_RX_ERR_EN to enable err_tgt_o and the debug drop
// counter u_err.cnt; otherwise err_tgt_o is 0 and bad flits vanish silently.
// -----------------------------------------------------------------------------
module dti_tniu_sys_side_mux
   import dti_tniu_sys_side_mux_pkg::*;
#(
   parameter int CH_NUM   = 4,
   parameter int DATA_W   = 80,
   parameter int KEEP_W   = 10,
   parameter int ID_W     = 6,
   parameter int LOCAL_ID = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   dti_tniu_sys_side_mux_if.slave dti_if,
   output logic                  err_tgt_o
);
   localparam int FLIT_W  = DATA_W + KEEP_W + 2 * ID_W + 2;
   localparam int SRC_LSB = flit_src_lsb(ID_W);
   localparam int RX_W    = DATA_W + KEEP_W + ID_W + 1;   // {data, keep, srcid, last}
   localparam int PTR_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [0:0] ST_IDLE   = ARB_IDLE;
   localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= CH_NUM) begin
         sum = sum - CH_NUM;
      end
      return PTR_W'(sum);
   endfunction

   // ---------------- TX arbiter + output register ----------------
   logic [0:0]        state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  gnt_q, gnt_d;
   logic [PTR_W-1:0]  sel_idx_s;
   logic              sel_found_s;
   logic              load_s;
   logic              tx_vld_q, tx_vld_d;
   logic [FLIT_W-1:0] tx_pld_q, tx_pld_d;
   logic [CH_NUM-1:0] tready_s;

   assign load_s = !tx_vld_q || dti_if.fl_tx_rdy;

   // Candidate selection: locked channel, or first valid at/after rr_ptr
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      if (state_q == ST_LOCKED) begin
         sel_idx_s   = gnt_q;
         sel_found_s = dti_if.up_rsp_tvalid[gnt_q];
      end else begin
         // Descending scan so the smallest offset from rr_ptr wins
         for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (dti_if.up_rsp_tvalid[wrap_idx(rr_ptr_q, k)]) begin
               sel_found_s = 1'b1;
               sel_idx_s   = wrap_idx(rr_ptr_q, k);
            end
         end
      end
   end

   // Arbiter next state and TX register load
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      tx_vld_d = tx_vld_q;
      tx_pld_d = tx_pld_q;
      if (load_s) begin
         tx_vld_d = sel_found_s;
         if (sel_found_s) begin
            tx_pld_d = {dti_if.up_rsp_tdata[sel_idx_s*DATA_W +: DATA_W],
                        dti_if.up_rsp_tkeep[sel_idx_s*KEEP_W +: KEEP_W],
                        ID_W'(LOCAL_ID),
                        dti_if.up_rsp_ttid[sel_idx_s*ID_W +: ID_W],
                        1'b1,
                        dti_if.up_rsp_tlast[sel_idx_s]};
            if (dti_if.up_rsp_tlast[sel_idx_s]) begin
               state_d  = ST_IDLE;
               rr_ptr_d = wrap_idx(sel_idx_s, 1);
            end else begin
               state_d = ST_LOCKED;
               gnt_d   = sel_idx_s;
            end
         end else begin
            tx_pld_d = tx_pld_q;
         end
      end else begin
         tx_vld_d = tx_vld_q;
      end
   end

   // Only the selected channel sees ready, and only when the register can load
   always_comb begin
      tready_s = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         tready_s[i] = load_s && sel_found_s && (sel_idx_s == PTR_W'(i));
      end
   end

   // TX state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         tx_vld_q <= 1'b0;
         tx_pld_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         tx_vld_q <= tx_vld_d;
         tx_pld_q <= tx_pld_d;
      end
   end

   assign dti_if.up_rsp_tready = tready_s;
   assign dti_if.fl_tx_vld     = tx_vld_q;
   assign dti_if.fl_tx_pld     = tx_pld_q;

   // ---------------- RX routing ----------------
   logic [ID_W-1:0]   rx_tgt_s;
   logic [PTR_W-1:0]  rx_idx_s;
   logic              rx_in_range_s;
   logic              rx_rdy_s;
   logic              rx_acc_s;
   logic              rx_qos_unused_s;
   logic [RX_W-1:0]   rx_entry_s;
   logic [CH_NUM-1:0] fifo_full_s;
   logic [CH_NUM-1:0] fifo_vld_s;
   logic [RX_W-1:0]   fifo_head_s [CH_NUM];

   assign rx_tgt_s        = dti_if.fl_rx_pld[FLIT_TGT_LSB +: ID_W];
   assign rx_idx_s        = rx_tgt_s[PTR_W-1:0];
   assign rx_in_range_s   = (32'(rx_tgt_s) < 32'(CH_NUM));
   assign rx_entry_s      = {dti_if.fl_rx_pld[FLIT_W-1:SRC_LSB], dti_if.fl_rx_pld[FLIT_LAST_BIT]};
   assign rx_qos_unused_s = dti_if.fl_rx_pld[FLIT_QOS_BIT];

   // Ready comes from registered FIFO counts only; bad targets are always sunk
   always_comb begin
      if (rx_in_range_s) begin
         rx_rdy_s = !fifo_full_s[rx_idx_s];
      end else begin
         rx_rdy_s = 1'b1;
      end
   end

   assign rx_acc_s         = dti_if.fl_rx_vld && rx_rdy_s;
   assign dti_if.fl_rx_rdy = rx_rdy_s;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      dti_tniu_skid2 #(.WIDTH(RX_W)) u_skid (
         .clk         (clk),
         .rst         (rst),
         .push_i      (rx_acc_s && rx_in_range_s && (rx_idx_s == PTR_W'(i))),
         .push_data_i (rx_entry_s),
         .pop_i       (fifo_vld_s[i] && dti_if.dn_req_tready[i]),
         .vld_o       (fifo_vld_s[i]),
         .data_o      (fifo_head_s[i]),
         .full_o      (fifo_full_s[i])
      );
      assign dti_if.dn_req_tvalid[i]                 = fifo_vld_s[i];
      assign dti_if.dn_req_tdata[i*DATA_W +: DATA_W] = fifo_head_s[i][RX_W-1 -: DATA_W];
      assign dti_if.dn_req_tkeep[i*KEEP_W +: KEEP_W] = fifo_head_s[i][1+ID_W +: KEEP_W];
      assign dti_if.dn_req_ttid[i*ID_W +: ID_W]      = fifo_head_s[i][1 +: ID_W];
      assign dti_if.dn_req_tlast[i]                  = fifo_head_s[i][0];
   end

`ifdef DTI_TNIU_RX_ERR_EN
   logic rx_drop_s;
   assign rx_drop_s = dti_if.fl_rx_vld && !rx_in_range_s;

   if (1) begin : u_err
      logic [7:0] cnt;
      logic       err_q;
      // Sticky error flag and saturating drop counter, cleared only by reset
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt   <= 8'd0;
            err_q <= 1'b0;
         end else if (rx_drop_s) begin
            err_q <= 1'b1;
            if (cnt != 8'hFF) begin
               cnt <= cnt + 8'd1;
            end
         end
      end
      assign err_tgt_o = err_q;
   end
`else
   assign err_tgt_o = 1'b0;
`endif

endmodule
